// File: rtl/clk_sched_pkg.sv
// Shared defaults and control-FSM state encoding for the clock-enable scheduler.
package clk_sched_pkg;

   localparam int N_CH_DEFAULT    = 4;
   localparam int CNT_W_DEFAULT   = 32;
   localparam int DEF_DIV_DEFAULT = 2;

   // IDLE accepts a configuration; APPLY writes it into the target channel.
   typedef enum logic {
      IDLE  = 1'b0,
      APPLY = 1'b1
   } cfg_state_e;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: divide/enable registers, phase counter, tick decode and
// square-wave output. tick comes straight off registers, so it has no
// combinational path from any input.
module tick_channel
   import clk_sched_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
   input  logic             clock_in,
   input  logic             rst,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   input  logic             wr_en,
   output logic             tick,
   output logic             clk_out
);

   logic [CNT_W-1:0] div_q;
   logic [CNT_W-1:0] cnt_q;
   logic             en_q;

   assign tick = en_q && (cnt_q == div_q - CNT_W'(1));

   // Divide ratio and enable change only on a configuration write.
   always_ff @(posedge clock_in or negedge rst) begin
      if (!rst) begin
         div_q <= CNT_W'(DEF_DIV);
         en_q  <= 1'b0;
      end else if (wr) begin
         div_q <= wr_div;
         en_q  <= wr_en;
      end
   end

   // Phase: a write or sync restarts it, disabled holds at zero, else count and wrap on tick.
   always_ff @(posedge clock_in or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         clk_out <= 1'b0;
      end else if (wr || sync || !en_q) begin
         cnt_q   <= '0;
         clk_out <= 1'b0;
      end else if (tick) begin
         cnt_q   <= '0;
         clk_out <= ~clk_out;
      end else begin
         cnt_q   <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/clk_enable_scheduler.sv
// Clock-enable scheduler: N_CH independent divide-by-D tick channels, each
// reconfigured through a two-state valid/ready handshake (accept, then apply).
module clk_enable_scheduler
   import clk_sched_pkg::*;
#(
   parameter int  N_CH    = N_CH_DEFAULT,
   parameter int  CNT_W   = CNT_W_DEFAULT,
   parameter int  DEF_DIV = DEF_DIV_DEFAULT,
   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clock_in,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             cfg_en,
   input  logic             sync_in,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  clk_out
);

   cfg_state_e       state_q, state_d;
   logic [CH_W-1:0]  lat_ch;
   logic [CNT_W-1:0] lat_div;
   logic             lat_en;

   // Control state register.
   always_ff @(posedge clock_in or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next state and ready: APPLY always lasts exactly one cycle.
   always_comb begin
      state_d   = state_q;
      cfg_ready = 1'b0;
      case (state_q)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) state_d = APPLY;
         end
         APPLY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture the request on accept; a zero ratio is stored as 1.
   always_ff @(posedge clock_in or negedge rst) begin
      if (!rst) begin
         lat_ch  <= '0;
         lat_div <= '0;
         lat_en  <= 1'b0;
      end else if (cfg_valid && cfg_ready) begin
         lat_ch  <= cfg_ch;
         lat_div <= (cfg_div == '0) ? CNT_W'(1) : cfg_div;
         lat_en  <= cfg_en;
      end
   end

   // A channel index with no matching instance selects nothing, so the
   // request still completes its APPLY cycle but is dropped.
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      tick_channel #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clock_in (clock_in),
         .rst      (rst),
         .sync     (sync_in),
         .wr       ((state_q == APPLY) && (lat_ch == CH_W'(g))),
         .wr_div   (lat_div),
         .wr_en    (lat_en),
         .tick     (tick[g]),
         .clk_out  (clk_out[g])
      );
   end

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Scoreboard bench: stimulus pushes the expected per-cycle outputs, a monitor
// pops and compares them just after each rising edge. Five channels so that a
// channel index of 5 is representable on the port but out of range.
module tb_clk_enable_scheduler;

   localparam int N   = 5;
   localparam int CW  = 32;
   localparam int CHW = 3;

   logic           clock_in = 1'b0;
   logic           rst;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [CHW-1:0] cfg_ch = '0;
   logic [CW-1:0]  cfg_div = '0;
   logic           cfg_en = 1'b0;
   logic           sync_in = 1'b0;
   logic [N-1:0]   tick;
   logic [N-1:0]   clk_out;

   clk_enable_scheduler #(.N_CH(N), .CNT_W(CW), .DEF_DIV(2)) u_dut (
      .clock_in  (clock_in),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_en    (cfg_en),
      .sync_in   (sync_in),
      .tick      (tick),
      .clk_out   (clk_out)
   );

   always #5 clock_in = ~clock_in;

   int cyc = 0;
   always @(posedge clock_in) cyc <= cyc + 1;

   typedef struct {
      int           cyc;
      string        name;
      logic [N-1:0] t;
      logic [N-1:0] c;
      logic         r;
   } exp_t;

   exp_t  sb[$];
   exp_t  mon_e;
   int    errors = 0;
   int    checks = 0;
   string ph = "reset";

   // Reference model: per channel enable, ratio and the cycle its phase restarted.
   bit m_en [N];
   int m_d  [N];
   int m_p  [N];

   task automatic check(string name, int k, logic [N-1:0] et, logic [N-1:0] ec, logic er);
      checks++;
      if (tick !== et || clk_out !== ec || cfg_ready !== er) begin
         errors++;
         $display("FAIL %s cyc=%0d got tick=%b clk_out=%b rdy=%b, want tick=%b clk_out=%b rdy=%b",
                  name, k, tick, clk_out, cfg_ready, et, ec, er);
      end
   endtask

   task automatic push(int k, logic r);
      exp_t e;
      e.cyc  = k;
      e.name = ph;
      e.r    = r;
      e.t    = '0;
      e.c    = '0;
      for (int i = 0; i < N; i++) begin
         if (m_en[i] && k >= m_p[i]) begin
            e.t[i] = (((k - m_p[i]) % m_d[i]) == m_d[i] - 1);
            e.c[i] = ((((k - m_p[i]) / m_d[i]) % 2) == 1);
         end
      end
      sb.push_back(e);
   endtask

   task automatic step();
      @(negedge clock_in);
   endtask

   task automatic drive(int ch, int div, bit en);
      cfg_ch  = CHW'(ch);
      cfg_div = CW'(div);
      cfg_en  = en;
   endtask

   task automatic window(int n);
      for (int j = 0; j < n; j++) begin
         push(cyc + 1, 1'b1);
         step();
      end
   endtask

   // One accepted configuration; optionally pulse sync onto the APPLY edge.
   task automatic cfg(int ch, int div, bit en, bit with_sync);
      cfg_valid = 1'b1;
      drive(ch, div, en);
      push(cyc + 1, 1'b0);
      step();
      cfg_valid = 1'b0;
      sync_in   = with_sync;
      if (with_sync)
         for (int i = 0; i < N; i++) m_p[i] = cyc + 1;
      if (ch < N) begin
         m_en[ch] = en;
         m_d[ch]  = (div == 0) ? 1 : div;
         m_p[ch]  = cyc + 1;
      end
      push(cyc + 1, 1'b1);
      step();
      sync_in = 1'b0;
   endtask

   task automatic sync_pulse();
      sync_in = 1'b1;
      for (int i = 0; i < N; i++) m_p[i] = cyc + 1;
      push(cyc + 1, 1'b1);
      step();
      sync_in = 1'b0;
   endtask

   // Monitor: compare every expectation due at this cycle.
   always @(posedge clock_in) begin
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.cyc != cyc) begin
            errors++;
            checks++;
            $display("FAIL %s stale expectation cyc=%0d seen at cyc=%0d", mon_e.name, mon_e.cyc, cyc);
         end else begin
            check(mon_e.name, cyc, mon_e.t, mon_e.c, mon_e.r);
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         m_en[i] = 1'b0;
         m_d[i]  = 2;
         m_p[i]  = 0;
      end
      rst = 1'b1;
      // A request held during reset must be ignored.
      cfg_valid = 1'b1;
      drive(0, 4, 1'b1);
      #2 rst = 1'b0;
      #1 check("reset_async", cyc, '0, '0, 1'b1);
      for (int j = 0; j < 3; j++) begin
         push(cyc + 1, 1'b1);
         step();
      end
      cfg_valid = 1'b0;
      rst       = 1'b1;

      ph = "idle_20";
      window(20);

      ph = "ch0_div4";
      cfg(0, 4, 1'b1, 1'b0);
      window(16);

      ph = "ch1_div3";
      cfg(1, 3, 1'b1, 1'b0);
      window(5);
      ph = "sync_mid";
      sync_pulse();
      window(12);

      ph = "ch2_div0";
      cfg(2, 0, 1'b1, 1'b0);
      window(6);

      ph = "ch5_discard";
      cfg(5, 7, 1'b1, 1'b0);
      window(8);

      // Valid held four cycles: only the first and third requests land.
      ph = "b2b";
      cfg_valid = 1'b1;
      drive(3, 2, 1'b1);
      push(cyc + 1, 1'b0);
      step();
      drive(4, 5, 1'b1);
      m_en[3] = 1'b1; m_d[3] = 2; m_p[3] = cyc + 1;
      push(cyc + 1, 1'b1);
      step();
      drive(4, 3, 1'b1);
      push(cyc + 1, 1'b0);
      step();
      drive(3, 6, 1'b0);
      m_en[4] = 1'b1; m_d[4] = 3; m_p[4] = cyc + 1;
      push(cyc + 1, 1'b1);
      step();
      cfg_valid = 1'b0;
      window(10);

      ph = "cfg_sync";
      cfg(1, 5, 1'b1, 1'b1);
      window(12);

      // Reset lands while ch3's request sits in APPLY.
      ph = "rst_apply";
      cfg_valid = 1'b1;
      drive(3, 10, 1'b1);
      push(cyc + 1, 1'b0);
      step();
      cfg_valid = 1'b0;
      rst = 1'b0;
      #1 check("rst_apply_async", cyc, '0, '0, 1'b1);
      for (int i = 0; i < N; i++) begin
         m_en[i] = 1'b0;
         m_d[i]  = 2;
      end
      for (int j = 0; j < 2; j++) begin
         push(cyc + 1, 1'b1);
         step();
      end
      rst = 1'b1;
      ph = "after_rst";
      window(14);

      for (int i = 0; i < 50 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
